// File: rtl/if1_id_fetch_buffer_if.sv
// IF1 -> fetch buffer -> ID handshake bundle. The master modport is the IF1/ID environment;
// the slave modport is the fetch buffer itself.
interface if1_id_fetch_buffer_if;
  logic        if1_valid;
  logic        if1_ready;
  logic [31:0] if1_pc;
  logic [31:0] if1_pc_next;
  logic [31:0] if1_inst;
  logic        if1_excp;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic [31:0] id_inst;
  logic        id_excp;

  modport master (
    output if1_valid, if1_pc, if1_pc_next, if1_inst, if1_excp, id_ready,
    input  if1_ready, id_valid, id_pc, id_pc_next, id_inst, id_excp
  );

  modport slave (
    input  if1_valid, if1_pc, if1_pc_next, if1_inst, if1_excp, id_ready,
    output if1_ready, id_valid, id_pc, id_pc_next, id_inst, id_excp
  );
endinterface

// File: rtl/if1_id_fetch_buffer.sv
// Circular FIFO between IF1 and ID holding {pc, pc_next, inst, excp} per fetched instruction.
// Define FETCH_BUF_BYPASS_EN to forward IF1 straight to ID when the buffer is empty.
`ifndef PC_RESET
`define PC_RESET 32'h1c00_0000
`endif

module if1_id_fetch_buffer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  if1_id_fetch_buffer_if.slave bus,
  output logic [PTR_W:0]       buf_count
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic        excp;
  } entry_t;

  localparam entry_t RST_ENTRY = '{pc: `PC_RESET, pc_next: `PC_RESET + 32'd8,
                                   inst: 32'h0340_0000, excp: 1'b0};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  entry_t           mem_q [DEPTH];
  entry_t           head, in_ent;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             empty, bypass, id_valid, push, pop_buf;

  assign in_ent = '{pc: bus.if1_pc, pc_next: bus.if1_pc_next,
                    inst: bus.if1_inst, excp: bus.if1_excp};
  assign empty  = (cnt_q == '0);

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = rstn & empty & bus.if1_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // Ready depends on registered occupancy only, so a full buffer refuses even while ID pops.
  assign bus.if1_ready = rstn & (cnt_q != CNT_FULL);
  assign id_valid      = rstn & ~flush & (~empty | bypass);
  assign bus.id_valid  = id_valid;

  always_comb begin
    head = RST_ENTRY;
    if (bypass)      head = in_ent;
    else if (!empty) head = mem_q[rd_q];
  end

  assign bus.id_pc      = head.pc;
  assign bus.id_pc_next = head.pc_next;
  assign bus.id_inst    = head.inst;
  assign bus.id_excp    = head.excp;
  assign buf_count      = cnt_q;

  // A bypassed instruction consumed by ID the same cycle never touches storage.
  assign pop_buf = id_valid & bus.id_ready & ~empty;
  assign push    = bus.if1_valid & bus.if1_ready & ~flush & ~(bypass & bus.id_ready);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push)    wr_d = wr_q + PTR_ONE;
      if (pop_buf) rd_d = rd_q + PTR_ONE;
      unique case ({push, pop_buf})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_ENTRY;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= in_ent;
    end
  end

`ifndef SYNTHESIS
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rstn) cnt_q <= CNT_FULL);
`endif
endmodule

// File: tb/tb_if1_id_fetch_buffer.sv
// Bench for if1_id_fetch_buffer: vector table, hand sequences, then random traffic vs a queue model.
`ifndef PC_RESET
`define PC_RESET 32'h1c00_0000
`endif

module tb_if1_id_fetch_buffer;
  localparam int DEPTH = 4;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] RST_PC = `PC_RESET;
  localparam logic [31:0] NOP    = 32'h0340_0000;
  localparam logic [31:0] A      = 32'h1c00_0000;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] buf_count;

  if1_id_fetch_buffer_if bus();

  if1_id_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(bus), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc, pcn, inst;
    logic        excp;
  } ent_t;
  ent_t q[$];

  typedef struct {
    bit          f, v, ir, pc_chk;
    logic [31:0] pc;
    bit          e_rdy, e_val;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;
  vec_t tv[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit f, input bit v, input logic [31:0] pc, input bit ir);
    flush           = f;
    bus.if1_valid   = v;
    bus.if1_pc      = pc;
    bus.if1_pc_next = pc + 32'd4;
    bus.if1_inst    = ~pc;
    bus.if1_excp    = pc[2];
    bus.id_ready    = ir;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, A,          1'b1, BYP,   BYP ? A : RST_PC, 0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, A + 32'h04, 1'b1, 1'b1,  A, 1};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, A + 32'h08, 1'b1, 1'b1,  A, 2};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, A + 32'h0c, 1'b1, 1'b1,  A, 3};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, A + 32'h10, 1'b0, 1'b1,  A, 4};
    tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, A + 32'h10, 1'b0, 1'b1,  A, 4};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,      1'b1, 1'b1,  A + 32'h04, 3};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,      1'b1, 1'b1,  A + 32'h08, 2};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,      1'b1, 1'b1,  A + 32'h0c, 1};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,      1'b1, 1'b0,  RST_PC, 0};
    tv[10] = '{1'b0, 1'b1, 1'b0, 1'b1, A + 32'h20, 1'b1, BYP,   BYP ? A + 32'h20 : RST_PC, 0};
    tv[11] = '{1'b0, 1'b1, 1'b0, 1'b1, A + 32'h24, 1'b1, 1'b1,  A + 32'h20, 1};
    tv[12] = '{1'b0, 1'b1, 1'b0, 1'b1, A + 32'h28, 1'b1, 1'b1,  A + 32'h20, 2};
    tv[13] = '{1'b1, 1'b1, 1'b1, 1'b0, A + 32'h100, 1'b1, 1'b0, 32'h0, 3};
    tv[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,      1'b1, 1'b0,  RST_PC, 0};
    tv[15] = '{1'b0, 1'b1, 1'b1, 1'b1, A + 32'h40, 1'b1, BYP,   BYP ? A + 32'h40 : RST_PC, 0};
    tv[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,      1'b1, !BYP,  BYP ? RST_PC : A + 32'h40, BYP ? 0 : 1};
    tv[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      1'b1, 1'b0,  RST_PC, 0};

    // Reset state
    drive(1'b0, 1'b1, A, 1'b1);
    #12;
    chk("rst_if1_ready", 32'(bus.if1_ready), 32'd0);
    chk("rst_id_valid",  32'(bus.id_valid),  32'd0);
    chk("rst_count",     32'(buf_count),     32'd0);
    chk("rst_id_pc",     bus.id_pc,          RST_PC);
    chk("rst_id_pc_next", bus.id_pc_next,    RST_PC + 32'd8);
    chk("rst_id_inst",   bus.id_inst,        NOP);
    chk("rst_id_excp",   32'(bus.id_excp),   32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_if1_ready", 32'(bus.if1_ready), 32'd1);
    next_cycle();

    // Fill/drain, full-refuse-while-pop, flush, empty-cycle forwarding
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].f, tv[i].v, tv[i].pc, tv[i].ir);
      @(negedge clk);
      chk($sformatf("tv%0d_if1_ready", i), 32'(bus.if1_ready), 32'(tv[i].e_rdy));
      chk($sformatf("tv%0d_id_valid", i),  32'(bus.id_valid),  32'(tv[i].e_val));
      chk($sformatf("tv%0d_count", i),     32'(buf_count),     32'(tv[i].e_cnt));
      if (tv[i].pc_chk) chk($sformatf("tv%0d_id_pc", i), bus.id_pc, tv[i].e_pc);
      next_cycle();
    end

    // Steady push+pop at count 2 across pointer wrap
    drive(1'b0, 1'b1, 32'h1c00_0200, 1'b0); next_cycle();
    drive(1'b0, 1'b1, 32'h1c00_0204, 1'b0); next_cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 32'h1c00_0208 + 32'(4 * k), 1'b1);
      @(negedge clk);
      chk($sformatf("pp%0d_count", k), 32'(buf_count), 32'd2);
      chk($sformatf("pp%0d_id_pc", k), bus.id_pc, 32'h1c00_0200 + 32'(4 * k));
      chk($sformatf("pp%0d_id_valid", k), 32'(bus.id_valid), 32'd1);
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk($sformatf("ppd%0d_id_pc", k), bus.id_pc, 32'h1c00_0218 + 32'(4 * k));
      next_cycle();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("pp_empty_count", 32'(buf_count), 32'd0);
    next_cycle();

    // Random traffic against a queue model
    q.delete();
    for (int n = 0; n < 400; n++) begin
      bit f, v, ir, byp, exp_val, exp_rdy;
      ent_t in, hd;
      f  = ($urandom_range(15) == 0);
      v  = ($urandom_range(3) != 0);
      ir = ($urandom_range(2) != 0);
      drive(f, v, $urandom() & 32'hffff_fffc, ir);
      bus.if1_inst = $urandom();
      bus.if1_excp = $urandom_range(1) == 1;
      in = '{bus.if1_pc, bus.if1_pc_next, bus.if1_inst, bus.if1_excp};
      exp_rdy = (q.size() < DEPTH);
      byp     = BYP && (q.size() == 0) && v && !f;
      exp_val = !f && (q.size() != 0 || byp);
      hd      = byp ? in : (q.size() != 0 ? q[0] : '{RST_PC, RST_PC + 32'd8, NOP, 1'b0});
      @(negedge clk);
      chk("rnd_if1_ready", 32'(bus.if1_ready), 32'(exp_rdy));
      chk("rnd_id_valid",  32'(bus.id_valid),  32'(exp_val));
      chk("rnd_count",     32'(buf_count),     32'(q.size()));
      chk("rnd_id_pc",     bus.id_pc,          hd.pc);
      chk("rnd_id_pc_next", bus.id_pc_next,    hd.pcn);
      chk("rnd_id_inst",   bus.id_inst,        hd.inst);
      chk("rnd_id_excp",   32'(bus.id_excp),   32'(hd.excp));
      if (f) q.delete();
      else begin
        if (exp_val && ir && q.size() != 0) void'(q.pop_front());
        if (v && exp_rdy && !(byp && ir)) q.push_back(in);
      end
      next_cycle();
    end

    // Asynchronous reset with a non-empty buffer
    drive(1'b1, 1'b0, 32'h0, 1'b0); next_cycle();
    drive(1'b0, 1'b1, 32'h1c00_0300, 1'b0); next_cycle();
    drive(1'b0, 1'b1, 32'h1c00_0304, 1'b0); next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("pre_arst_count", 32'(buf_count), 32'd2);
    rstn = 1'b0;
    #1;
    chk("arst_count",    32'(buf_count),     32'd0);
    chk("arst_id_valid", 32'(bus.id_valid),  32'd0);
    chk("arst_ready",    32'(bus.if1_ready), 32'd0);
    chk("arst_id_pc",    bus.id_pc,          RST_PC);
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
